// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters (CPU port C, external port E), the
// data-memory arbiter, and the single-port data memory.
interface data_mem_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_stall;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;

  logic          e_req;
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic          e_gnt;
  logic          e_rvalid;
  logic [DW-1:0] e_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  e_req, e_we, e_addr, e_wdata,
    input  mem_rdata,
    output c_gnt, c_stall, c_rvalid, c_rdata,
    output e_gnt, e_rvalid, e_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters plus memory side.
  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output e_req, e_we, e_addr, e_wdata,
    output mem_rdata,
    input  c_gnt, c_stall, c_rvalid, c_rdata,
    input  e_gnt, e_rvalid, e_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: registered owner
// with bounded hold, combinational grants, one-cycle read return tagged by port.
module data_mem_arbiter #(
  parameter int AW       = 11,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_arbiter_if.slave  bus
);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, OWN_C, OWN_E} state_t;

  state_t        state;
  logic          lastOwner;  // 0 = C, 1 = E
  logic [HW-1:0] holdCnt;
  logic          cRvalid, eRvalid;

  logic          cGnt, eGnt, lastBeat, holdSat;
  logic [AW-1:0] cmdAddr;
  logic [DW-1:0] cmdWdata;

  assign cGnt     = (state == OWN_C) && bus.c_req;
  assign eGnt     = (state == OWN_E) && bus.e_req;
  // holdCnt saturates so a long solo run still yields on the first beat the other side waits.
  assign lastBeat = holdCnt >= HW'(MAX_HOLD - 1);
  assign holdSat  = holdCnt == HW'(MAX_HOLD);

  assign cmdAddr  = ({AW{cGnt}} & bus.c_addr)  | ({AW{eGnt}} & bus.e_addr);
  assign cmdWdata = ({DW{cGnt}} & bus.c_wdata) | ({DW{eGnt}} & bus.e_wdata);

  assign bus.c_gnt     = cGnt;
  assign bus.e_gnt     = eGnt;
  assign bus.c_stall   = bus.c_req && !cGnt;
  assign bus.mem_en    = cGnt || eGnt;
  assign bus.mem_we    = (cGnt && bus.c_we) || (eGnt && bus.e_we);
  assign bus.mem_addr  = cmdAddr;
  assign bus.mem_wdata = cmdWdata;
  assign bus.c_rvalid  = cRvalid;
  assign bus.e_rvalid  = eRvalid;
  assign bus.c_rdata   = bus.mem_rdata;
  assign bus.e_rdata   = bus.mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lastOwner <= 1'b1;
      holdCnt   <= '0;
      cRvalid   <= 1'b0;
      eRvalid   <= 1'b0;
    end else begin
      cRvalid <= cGnt && !bus.c_we;
      eRvalid <= eGnt && !bus.e_we;
      unique case (state)
        IDLE: begin
          holdCnt <= '0;
          if (bus.c_req && bus.e_req) state <= lastOwner ? OWN_C : OWN_E;
          else if (bus.c_req)         state <= OWN_C;
          else if (bus.e_req)         state <= OWN_E;
        end
        OWN_C: begin
          if (!bus.c_req) begin
            state     <= bus.e_req ? OWN_E : IDLE;
            lastOwner <= 1'b0;
            holdCnt   <= '0;
          end else if (bus.e_req && lastBeat) begin
            state     <= OWN_E;
            lastOwner <= 1'b0;
            holdCnt   <= '0;
          end else if (!holdSat) begin
            holdCnt <= holdCnt + 1'b1;
          end
        end
        OWN_E: begin
          if (!bus.e_req) begin
            state     <= bus.c_req ? OWN_C : IDLE;
            lastOwner <= 1'b1;
            holdCnt   <= '0;
          end else if (bus.c_req && lastBeat) begin
            state     <= OWN_C;
            lastOwner <= 1'b1;
            holdCnt   <= '0;
          end else if (!holdSat) begin
            holdCnt <= holdCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against a port-ownership model.
module tb_data_mem_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  data_mem_arbiter_if #(.AW(AW), .DW(DW)) bus();
  data_mem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  function automatic logic [DW-1:0] memInit(input logic [AW-1:0] a);
    if (a == 11'h010) return 32'hDEADBEEF;
    return (32'(a) * 32'h9E3779B9) + 32'h0BADF00D;
  endfunction

  // Memory behind the arbiter: unwritten words read their initial pattern.
  logic [DW-1:0] memArr [2**AW];
  bit            memWr  [2**AW];
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we) begin
        memArr[bus.mem_addr] <= bus.mem_wdata;
        memWr[bus.mem_addr]  <= 1'b1;
      end else begin
        bus.mem_rdata <= memWr[bus.mem_addr] ? memArr[bus.mem_addr] : memInit(bus.mem_addr);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the memory, how many beats it has had, who owned last.
  int            mOwner = 0;  // 0 none, 1 C, 2 E
  int            mLast  = 2;
  int            mBeats = 0;
  bit            mCrv = 0, mErv = 0;
  logic [DW-1:0] mCrd, mErd;
  logic [DW-1:0] refMem [int];
  bit            lastCG = 0, lastEG = 0;

  function automatic logic [DW-1:0] refRead(input logic [AW-1:0] a);
    return refMem.exists(int'(a)) ? refMem[int'(a)] : memInit(a);
  endfunction

  always @(negedge clk) begin
    bit eC, eE, xReq, yReq;
    logic [AW-1:0] eA;
    logic [DW-1:0] eD;
    eC = (mOwner == 1) && bus.c_req;
    eE = (mOwner == 2) && bus.e_req;
    eA = eC ? bus.c_addr  : eE ? bus.e_addr  : '0;
    eD = eC ? bus.c_wdata : eE ? bus.e_wdata : '0;
    chk("c_gnt",     bus.c_gnt,    eC);
    chk("e_gnt",     bus.e_gnt,    eE);
    chk("c_stall",   bus.c_stall,  bus.c_req && !eC);
    chk("mem_en",    bus.mem_en,   eC || eE);
    chk("mem_we",    bus.mem_we,   (eC && bus.c_we) || (eE && bus.e_we));
    chk("mem_addr",  bus.mem_addr, eA);
    chk("mem_wdata", bus.mem_wdata, eD);
    chk("c_rvalid",  bus.c_rvalid, mCrv);
    chk("e_rvalid",  bus.e_rvalid, mErv);
    if (mCrv) chk("c_rdata", bus.c_rdata, mCrd);
    if (mErv) chk("e_rdata", bus.e_rdata, mErd);
    lastCG = eC;
    lastEG = eE;

    // Advance to the state after the coming edge.
    if (eC && !bus.c_we) mCrd = refRead(bus.c_addr);
    if (eE && !bus.e_we) mErd = refRead(bus.e_addr);
    if (eC && bus.c_we) refMem[int'(bus.c_addr)] = bus.c_wdata;
    if (eE && bus.e_we) refMem[int'(bus.e_addr)] = bus.e_wdata;
    if (rst) begin
      mOwner = 0; mLast = 2; mBeats = 0; mCrv = 0; mErv = 0;
    end else begin
      mCrv = eC && !bus.c_we;
      mErv = eE && !bus.e_we;
      if (mOwner == 0) begin
        mBeats = 0;
        if (bus.c_req && bus.e_req) mOwner = (mLast == 2) ? 1 : 2;
        else if (bus.c_req)         mOwner = 1;
        else if (bus.e_req)         mOwner = 2;
      end else begin
        xReq = (mOwner == 1) ? bus.c_req : bus.e_req;
        yReq = (mOwner == 1) ? bus.e_req : bus.c_req;
        if (!xReq) begin
          mLast = mOwner; mOwner = yReq ? 3 - mOwner : 0; mBeats = 0;
        end else begin
          mBeats++;
          if (yReq && mBeats >= MH) begin
            mLast = mOwner; mOwner = 3 - mOwner; mBeats = 0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setC(input bit r, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.c_req = r; bus.c_we = we; bus.c_addr = a; bus.c_wdata = d;
  endtask

  task automatic setE(input bit r, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.e_req = r; bus.e_we = we; bus.e_addr = a; bus.e_wdata = d;
  endtask

  task automatic doReset();
    setC(0, 0, '0, '0);
    setE(0, 0, '0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int seq [9];
    int expSeq [9] = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
    bit ok;

    // Reset with both requests high, then continuous contention.
    setC(1, 0, 11'h001, '0);
    setE(1, 0, 11'h002, '0);
    rst = 1'b1;
    step(); step();
    #1;
    chk("rst c_gnt",  bus.c_gnt,  1'b0);
    chk("rst e_gnt",  bus.e_gnt,  1'b0);
    chk("rst mem_en", bus.mem_en, 1'b0);
    chk("rst rvalid", {bus.c_rvalid, bus.e_rvalid}, 2'b00);
    rst = 1'b0;
    #1;
    chk("release no gnt", {bus.c_gnt, bus.e_gnt}, 2'b00);
    for (int k = 0; k < 9; k++) begin
      step();
      bus.c_addr = 11'(k + 3);
      bus.e_addr = 11'(k + 40);
      #1;
      seq[k] = bus.c_gnt ? 1 : bus.e_gnt ? 2 : 0;
    end
    ok = 1'b1;
    for (int k = 0; k < 9; k++) if (seq[k] != expSeq[k]) ok = 1'b0;
    chk("grant pattern CCCCEEEEC", ok, 1'b1);

    // CPU-only read of 0x010.
    doReset();
    setC(1, 0, 11'h010, '0);
    step();
    #1;
    chk("T2 c_gnt",    bus.c_gnt,    1'b1);
    chk("T2 mem_en",   bus.mem_en,   1'b1);
    chk("T2 mem_addr", bus.mem_addr, 11'h010);
    step();
    bus.c_req = 1'b0;
    #1;
    chk("T2 c_rvalid", bus.c_rvalid, 1'b1);
    chk("T2 c_rdata",  bus.c_rdata,  32'hDEADBEEF);
    chk("T2 e_rvalid", bus.e_rvalid, 1'b0);

    // CPU owns, E waits, CPU drops after two beats.
    doReset();
    setC(1, 0, 11'h020, '0);
    step();
    setE(1, 0, 11'h021, '0);
    #1;
    chk("T4 beat1", bus.c_gnt, 1'b1);
    step();
    #1;
    chk("T4 beat2", bus.c_gnt, 1'b1);
    step();
    bus.c_req = 1'b0;
    #1;
    chk("T4 drop no gnt", {bus.c_gnt, bus.e_gnt}, 2'b00);
    step();
    bus.c_req = 1'b1;
    #1;
    chk("T4 handoff e_gnt", bus.e_gnt, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      chk("T4 e hold beat", bus.e_gnt, 1'b1);
    end
    step();
    #1;
    chk("T4 back to C", bus.c_gnt, 1'b1);

    // E write then read of 0x7FF.
    doReset();
    setE(1, 1, 11'h7FF, 32'h5);
    step();
    #1;
    chk("T5 wr e_gnt",    bus.e_gnt,    1'b1);
    chk("T5 wr mem_we",   bus.mem_we,   1'b1);
    chk("T5 wr mem_addr", bus.mem_addr, 11'h7FF);
    step();
    bus.e_we = 1'b0;
    #1;
    chk("T5 rd e_gnt",        bus.e_gnt,    1'b1);
    chk("T5 no rvalid on wr", bus.e_rvalid, 1'b0);
    step();
    bus.e_req = 1'b0;
    #1;
    chk("T5 e_rvalid", bus.e_rvalid, 1'b1);
    chk("T5 e_rdata",  bus.e_rdata,  32'h5);

    // Reset in the cycle a CPU read is granted.
    doReset();
    setC(1, 0, 11'h005, '0);
    step();
    rst = 1'b1;
    #1;
    chk("T6 c_gnt", bus.c_gnt, 1'b1);
    step();
    rst = 1'b0;
    setE(1, 0, 11'h006, '0);
    #1;
    chk("T6 no c_rvalid", bus.c_rvalid, 1'b0);
    chk("T6 idle",        {bus.c_gnt, bus.e_gnt}, 2'b00);
    step();
    #1;
    chk("T6 C wins tie", bus.c_gnt, 1'b1);

    // Random traffic; requests are held until granted.
    doReset();
    for (int n = 0; n < 4000; n++) begin
      step();
      rst = ($urandom_range(299) == 0);
      if (lastCG) bus.c_req = 1'b0;
      if (lastEG) bus.e_req = 1'b0;
      if (!bus.c_req && $urandom_range(2) != 0)
        setC(1, 1'($urandom), 11'($urandom_range(15)) | ($urandom_range(1) ? 11'h7F0 : 11'h000), $urandom);
      if (!bus.e_req && $urandom_range(2) != 0)
        setE(1, 1'($urandom), 11'($urandom_range(15)) | ($urandom_range(1) ? 11'h7F0 : 11'h000), $urandom);
    end
    setC(0, 0, '0, '0);
    setE(0, 0, '0, '0);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
